// File: rtl/pipe_reg_memwb.sv
// MEM/WB pipeline stage register with valid tracking, stall/flush and a registered write-back select.
// Optional retired/bubble performance counters are built in when PIPE_MEMWB_PERF_EN is defined.
module pipe_reg_memwb #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned MEMTOREG_WIDTH = 2
`ifdef PIPE_MEMWB_PERF_EN
    ,parameter int unsigned CNT_WIDTH     = 32
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      flush,
    input  logic                      valid_in,
    input  logic                      reg_write_in,
    input  logic [MEMTOREG_WIDTH-1:0] mem_to_reg_in,
    input  logic [DATA_WIDTH-1:0]     alu_result_in,
    input  logic [DATA_WIDTH-1:0]     mem_data_in,
    input  logic [DATA_WIDTH-1:0]     pc_plus4_in,
    input  logic [REG_ADDR_WIDTH-1:0] write_reg_in,
    output logic                      valid_out,
    output logic                      reg_write_out,
    output logic [MEMTOREG_WIDTH-1:0] mem_to_reg_out,
    output logic [REG_ADDR_WIDTH-1:0] write_reg_out,
    output logic [DATA_WIDTH-1:0]     wb_data_out,
    output logic                      wb_we_out
`ifdef PIPE_MEMWB_PERF_EN
    ,output logic [CNT_WIDTH-1:0]     retired_cnt
    ,output logic [CNT_WIDTH-1:0]     bubble_cnt
`endif
);

    localparam logic [MEMTOREG_WIDTH-1:0] SEL_ALU = MEMTOREG_WIDTH'(0);
    localparam logic [MEMTOREG_WIDTH-1:0] SEL_MEM = MEMTOREG_WIDTH'(1);
    localparam logic [MEMTOREG_WIDTH-1:0] SEL_PC4 = MEMTOREG_WIDTH'(2);

    typedef struct packed {
        logic                      valid;
        logic                      reg_write;
        logic [MEMTOREG_WIDTH-1:0] mem_to_reg;
        logic [REG_ADDR_WIDTH-1:0] write_reg;
        logic [DATA_WIDTH-1:0]     alu_result;
        logic [DATA_WIDTH-1:0]     mem_data;
        logic [DATA_WIDTH-1:0]     pc_plus4;
    } stage_t;

    stage_t stage_q, stage_d;

    // Next-state: flush kills the slot even while stalled; otherwise load or hold.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (enable) begin
            stage_d.valid      = valid_in;
            stage_d.reg_write  = reg_write_in;
            stage_d.mem_to_reg = mem_to_reg_in;
            stage_d.write_reg  = write_reg_in;
            stage_d.alu_result = alu_result_in;
            stage_d.mem_data   = mem_data_in;
            stage_d.pc_plus4   = pc_plus4_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign valid_out      = stage_q.valid;
    assign reg_write_out  = stage_q.reg_write;
    assign mem_to_reg_out = stage_q.mem_to_reg;
    assign write_reg_out  = stage_q.write_reg;

    // Write-back source select; unused encodings drive zero.
    always_comb begin
        wb_data_out = '0;
        case (stage_q.mem_to_reg)
            SEL_ALU: wb_data_out = stage_q.alu_result;
            SEL_MEM: wb_data_out = stage_q.mem_data;
            SEL_PC4: wb_data_out = stage_q.pc_plus4;
            default: wb_data_out = '0;
        endcase
    end

    assign wb_we_out = stage_q.valid & stage_q.reg_write & (stage_q.write_reg != '0);

`ifdef PIPE_MEMWB_PERF_EN
    logic [CNT_WIDTH-1:0] retired_q, retired_d;
    logic [CNT_WIDTH-1:0] bubble_q,  bubble_d;

    // Count the slot leaving the stage on each productive edge; saturate at all-ones.
    always_comb begin
        retired_d = retired_q;
        bubble_d  = bubble_q;
        if (enable && !flush) begin
            if (stage_q.valid) begin
                if (retired_q != '1) retired_d = retired_q + CNT_WIDTH'(1);
            end else begin
                if (bubble_q != '1) bubble_d = bubble_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
            bubble_q  <= '0;
        end else begin
            retired_q <= retired_d;
            bubble_q  <= bubble_d;
        end
    end

    assign retired_cnt = retired_q;
    assign bubble_cnt  = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_reg_memwb.sv
// Directed self-checking bench for pipe_reg_memwb (counter checks when PIPE_MEMWB_PERF_EN is defined).
module tb_pipe_reg_memwb;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned MW = 2;
`ifdef PIPE_MEMWB_PERF_EN
    localparam int unsigned CW = 4;
`endif

    logic          clk = 1'b0;
    logic          reset, enable, flush, valid_in, reg_write_in;
    logic [MW-1:0] mem_to_reg_in;
    logic [DW-1:0] alu_result_in, mem_data_in, pc_plus4_in;
    logic [AW-1:0] write_reg_in;
    logic          valid_out, reg_write_out, wb_we_out;
    logic [MW-1:0] mem_to_reg_out;
    logic [AW-1:0] write_reg_out;
    logic [DW-1:0] wb_data_out;
`ifdef PIPE_MEMWB_PERF_EN
    logic [CW-1:0] retired_cnt, bubble_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_reg_memwb #(
        .DATA_WIDTH    (DW),
        .REG_ADDR_WIDTH(AW),
        .MEMTOREG_WIDTH(MW)
`ifdef PIPE_MEMWB_PERF_EN
        ,.CNT_WIDTH    (CW)
`endif
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .flush         (flush),
        .valid_in      (valid_in),
        .reg_write_in  (reg_write_in),
        .mem_to_reg_in (mem_to_reg_in),
        .alu_result_in (alu_result_in),
        .mem_data_in   (mem_data_in),
        .pc_plus4_in   (pc_plus4_in),
        .write_reg_in  (write_reg_in),
        .valid_out     (valid_out),
        .reg_write_out (reg_write_out),
        .mem_to_reg_out(mem_to_reg_out),
        .write_reg_out (write_reg_out),
        .wb_data_out   (wb_data_out),
        .wb_we_out     (wb_we_out)
`ifdef PIPE_MEMWB_PERF_EN
        ,.retired_cnt  (retired_cnt)
        ,.bubble_cnt   (bubble_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic fl, input logic v, input logic rw,
                         input logic [MW-1:0] m2r, input logic [DW-1:0] alu,
                         input logic [DW-1:0] mem, input logic [DW-1:0] pc4,
                         input logic [AW-1:0] wr);
        enable        = en;
        flush         = fl;
        valid_in      = v;
        reg_write_in  = rw;
        mem_to_reg_in = m2r;
        alu_result_in = alu;
        mem_data_in   = mem;
        pc_plus4_in   = pc4;
        write_reg_in  = wr;
    endtask

    initial begin
        // Reset for two cycles with every input high
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, '1, '1, '1, '1, '1);
        tick();
        tick();
        check("rst_valid",     64'(valid_out),      64'd0);
        check("rst_regwrite",  64'(reg_write_out),  64'd0);
        check("rst_memtoreg",  64'(mem_to_reg_out), 64'd0);
        check("rst_writereg",  64'(write_reg_out),  64'd0);
        check("rst_wbdata",    64'(wb_data_out),    64'd0);
        check("rst_wbwe",      64'(wb_we_out),      64'd0);
`ifdef PIPE_MEMWB_PERF_EN
        check("rst_retired",   64'(retired_cnt),    64'd0);
        check("rst_bubble",    64'(bubble_cnt),     64'd0);
`endif
        reset = 1'b0;

        // Memory-data write-back, then PC+4, unused select, ALU
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0000_0404, 5'd5);
        tick();
        check("mem_wbdata",    64'(wb_data_out),    64'hDEAD_BEEF);
        check("mem_wbwe",      64'(wb_we_out),      64'd1);
        check("mem_writereg",  64'(write_reg_out),  64'd5);
        check("mem_valid",     64'(valid_out),      64'd1);
        check("mem_memtoreg",  64'(mem_to_reg_out), 64'd1);
        mem_to_reg_in = 2'd2;
        tick();
        check("pc4_wbdata",    64'(wb_data_out),    64'h0000_0404);
        mem_to_reg_in = 2'd3;
        tick();
        check("sel3_wbdata",   64'(wb_data_out),    64'd0);
        mem_to_reg_in = 2'd0;
        tick();
        check("alu_wbdata",    64'(wb_data_out),    64'h1111_1111);

        // Load 0x1234 then stall three cycles with changing inputs
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0000_1234, 32'h0, 32'h0, 5'd7);
        tick();
        check("load_wbdata",   64'(wb_data_out),    64'h1234);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'hAAAA_0000 + 32'(i), 32'h5555_5555, 32'h0, 5'd9);
            tick();
            check("stall_wbdata",   64'(wb_data_out),   64'h1234);
            check("stall_writereg", 64'(write_reg_out), 64'd7);
            check("stall_valid",    64'(valid_out),     64'd1);
        end

        // Flush while stalled kills the held entry
        flush = 1'b1;
        tick();
        check("flush_valid",    64'(valid_out),     64'd0);
        check("flush_wbwe",     64'(wb_we_out),     64'd0);
        check("flush_wbdata",   64'(wb_data_out),   64'd0);
        check("flush_regwrite", 64'(reg_write_out), 64'd0);
        check("flush_writereg", 64'(write_reg_out), 64'd0);

        // Destination r0 is never written
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0000_ABCD, 32'h0, 32'h0, 5'd0);
        tick();
        check("r0_regwrite",    64'(reg_write_out), 64'd1);
        check("r0_wbwe",        64'(wb_we_out),     64'd0);
        check("r0_valid",       64'(valid_out),     64'd1);

        // Bubble: valid_in=0 masks the write enable
        drive(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0000_0042, 32'h0, 32'h0, 5'd3);
        tick();
        check("bub_valid",      64'(valid_out),     64'd0);
        check("bub_regwrite",   64'(reg_write_out), 64'd1);
        check("bub_wbwe",       64'(wb_we_out),     64'd0);

        // Flush beats enable=1
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0000_0077, 32'h0, 32'h0, 5'd4);
        tick();
        check("pre_flush_wbwe", 64'(wb_we_out),     64'd1);
        flush = 1'b1;
        tick();
        check("flush_en_valid", 64'(valid_out),     64'd0);
        check("flush_en_wbdat", 64'(wb_data_out),   64'd0);

        // Reset during a stall clears a valid entry
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0000_0099, 32'h0, 32'h0, 5'd6);
        tick();
        check("pre_rst_valid",  64'(valid_out),     64'd1);
        enable = 1'b0;
        reset  = 1'b1;
        tick();
        check("rst_stall_valid",  64'(valid_out),   64'd0);
        check("rst_stall_wbdata", 64'(wb_data_out), 64'd0);
        check("rst_stall_wr",     64'(write_reg_out), 64'd0);

`ifdef PIPE_MEMWB_PERF_EN
        // Counters: first edge retires the reset bubble, next 19 saturate retired at 15
        tick();
        check("perf_rst_ret",   64'(retired_cnt),   64'd0);
        check("perf_rst_bub",   64'(bubble_cnt),    64'd0);
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 32'h1, 32'h0, 32'h0, 5'd1);
        for (int i = 0; i < 20; i++) tick();
        check("perf_retired",   64'(retired_cnt),   64'd15);
        check("perf_bubble",    64'(bubble_cnt),    64'd1);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("perf_stall_ret", 64'(retired_cnt),   64'd15);
        check("perf_stall_bub", 64'(bubble_cnt),    64'd1);
        flush = 1'b1;
        tick();
        check("perf_flush_bub", 64'(bubble_cnt),    64'd1);
        flush  = 1'b0;
        enable = 1'b1;
        tick();
        check("perf_after_bub", 64'(bubble_cnt),    64'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
